// File: rtl/nms_window_gen.sv
// 3x3 gradient window generator feeding non-maximum suppression.
// Two line buffers plus a 3x3 shift window; one window per interior pixel, one clock after its last pixel.
module nms_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MAG_W      = 11,
    parameter int DIR_W      = 2
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [MAG_W-1:0]     in_magnitude,
    input  logic [DIR_W-1:0]     in_direction,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic [9*MAG_W-1:0]   gradient_magnitude,
    output logic [9*DIR_W-1:0]   gradient_direction,
    output logic                 gradient_data_valid,
    output logic                 window_eof
);

    localparam int PIX_W = MAG_W + DIR_W;
    localparam int CW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef logic [PIX_W-1:0] pix_t;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          valid_q, valid_d;
    logic          eof_q, eof_d;
    pix_t          in_pix;
    pix_t          col_new [3];

    pix_t lb_a [IMG_WIDTH];
    pix_t lb_b [IMG_WIDTH];

    assign in_pix = {in_magnitude, in_direction};

    // A start-of-frame marker overrides the counters so the pixel lands at (0,0).
    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        eof_d   = 1'b0;
        if (in_valid) begin
            valid_d = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            eof_d   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
        end
    end

    // Line buffers carry no reset; stale contents are flushed by two fresh rows before any valid window.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_a[cur_col] <= lb_b[cur_col];
            lb_b[cur_col] <= in_pix;
        end
    end

    always_comb begin
        col_new[0] = lb_a[cur_col];
        col_new[1] = lb_b[cur_col];
        col_new[2] = in_pix;
    end

    assign gradient_data_valid = valid_q;
    assign window_eof          = eof_q;

    // One generate row per window line; slot k = 3*row + col, col 0 is the oldest column.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            pix_t c0_q, c1_q, c2_q;

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    c0_q <= '0;
                    c1_q <= '0;
                    c2_q <= '0;
                end else if (in_valid) begin
                    c0_q <= c1_q;
                    c1_q <= c2_q;
                    c2_q <= col_new[gi];
                end
            end

            assign gradient_magnitude[MAG_W*(3*gi+0) +: MAG_W] = c0_q[PIX_W-1:DIR_W];
            assign gradient_magnitude[MAG_W*(3*gi+1) +: MAG_W] = c1_q[PIX_W-1:DIR_W];
            assign gradient_magnitude[MAG_W*(3*gi+2) +: MAG_W] = c2_q[PIX_W-1:DIR_W];
            assign gradient_direction[DIR_W*(3*gi+0) +: DIR_W] = c0_q[DIR_W-1:0];
            assign gradient_direction[DIR_W*(3*gi+1) +: DIR_W] = c1_q[DIR_W-1:0];
            assign gradient_direction[DIR_W*(3*gi+2) +: DIR_W] = c2_q[DIR_W-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_nms_window_gen.sv
// Self-checking bench for nms_window_gen on a 4x4 image.
// The reference keeps the whole image as a 2-D array and cuts 3x3 neighbourhoods out of it.
module tb_nms_window_gen;

    localparam int W = 4;
    localparam int H = 4;
    localparam int MW = 11;
    localparam int DW = 2;

    logic            clk;
    logic            rstN;
    logic [MW-1:0]   in_magnitude;
    logic [DW-1:0]   in_direction;
    logic            in_valid;
    logic            in_sof;
    logic [9*MW-1:0] gradient_magnitude;
    logic [9*DW-1:0] gradient_direction;
    logic            gradient_data_valid;
    logic            window_eof;

    nms_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .MAG_W     (MW),
        .DIR_W     (DW)
    ) dut (
        .clk                (clk),
        .rstN               (rstN),
        .in_magnitude       (in_magnitude),
        .in_direction       (in_direction),
        .in_valid           (in_valid),
        .in_sof             (in_sof),
        .gradient_magnitude (gradient_magnitude),
        .gradient_direction (gradient_direction),
        .gradient_data_valid(gradient_data_valid),
        .window_eof         (window_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int strobes = 0;

    // Reference model state: image contents and the raster position of the next pixel.
    logic [MW+DW-1:0] img [H][W];
    int               mr = 0;
    int               mc = 0;
    logic             known = 1'b0;
    logic [9*MW-1:0]  exp_mag = '0;
    logic [9*DW-1:0]  exp_dir = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [MW-1:0] m, input logic [DW-1:0] d);
        int R;
        int C;
        logic ev;
        logic ee;
        in_valid     = v;
        in_sof       = s;
        in_magnitude = m;
        in_direction = d;
        @(posedge clk);
        #1;
        ev = 1'b0;
        ee = 1'b0;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            R = mr;
            C = mc;
            img[R][C] = {m, d};
            ev = (R >= 2) && (C >= 2);
            ee = (R == H - 1) && (C == W - 1);
            if (ev) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        exp_mag[MW*(3*r+c) +: MW] = img[R-2+r][C-2+c][MW+DW-1:DW];
                        exp_dir[DW*(3*r+c) +: DW] = img[R-2+r][C-2+c][DW-1:0];
                    end
                end
            end
            known = ev;
            mc = mc + 1;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        $display("cyc v=%0b sof=%0b pix=%0d/%0d -> valid=%0b eof=%0b k4=%0d", v, s, m, d,
                 gradient_data_valid, window_eof, gradient_magnitude[MW*4 +: MW]);
        chk("valid", 128'(gradient_data_valid), 128'(ev));
        chk("eof", 128'(window_eof), 128'(ee));
        if (gradient_data_valid) strobes++;
        if (ev || (!v && known)) begin
            chk("mag", 128'(gradient_magnitude), 128'(exp_mag));
            chk("dir", 128'(gradient_direction), 128'(exp_dir));
        end
    endtask

    task automatic pix(input int r, input int c, input int off, input logic s);
        logic [MW-1:0] m;
        logic [DW-1:0] d;
        m = MW'(10 * r + c + off);
        d = DW'((r + c) % 4);
        cycle(1'b1, s, m, d);
    endtask

    task automatic chk_first_window(input string tag, input int off);
        int ref_m [9];
        int ref_d [9];
        logic [9*MW-1:0] pm;
        logic [9*DW-1:0] pd;
        ref_m = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        ref_d = '{0, 1, 2, 1, 2, 3, 2, 3, 0};
        for (int k = 0; k < 9; k++) begin
            pm[MW*k +: MW] = MW'(ref_m[k] + off);
            pd[DW*k +: DW] = DW'(ref_d[k]);
        end
        chk({tag, "_mag"}, 128'(gradient_magnitude), 128'(pm));
        chk({tag, "_dir"}, 128'(gradient_direction), 128'(pd));
        chk({tag, "_centre_dir"}, 128'(gradient_direction[9:8]), 128'(2'd2));
    endtask

    initial begin
        rstN         = 1'b0;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        in_magnitude = '0;
        in_direction = '0;
        #12;
        chk("rst_valid", 128'(gradient_data_valid), 128'(0));
        chk("rst_eof", 128'(window_eof), 128'(0));
        chk("rst_mag", 128'(gradient_magnitude), 128'(0));
        chk("rst_dir", 128'(gradient_direction), 128'(0));
        @(posedge clk);
        #1;
        rstN = 1'b1;
        cycle(1'b0, 1'b0, '0, '0);

        // Full frame, no gaps, sof on first pixel
        strobes = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pix(r, c, 0, (r == 0 && c == 0));
                if (r == 2 && c == 2) chk_first_window("t1_first", 0);
            end
        end
        cycle(1'b0, 1'b0, '0, '0);
        chk("t1_strobes", 128'(strobes), 128'((W - 2) * (H - 2)));

        // Same frame with random idle gaps; sof during gaps must be ignored
        strobes = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pix(r, c, 0, (r == 0 && c == 0));
                repeat ($urandom_range(1, 3)) cycle(1'b0, 1'($urandom), MW'($urandom), DW'($urandom));
            end
        end
        chk("t3_strobes", 128'(strobes), 128'((W - 2) * (H - 2)));

        // Two frames back-to-back, second frame without sof and offset by 100
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    pix(r, c, 100 * f, (f == 0 && r == 0 && c == 0));
                    if (f == 1 && r == 2 && c == 2) begin
                        chk("t4_k4", 128'(gradient_magnitude[MW*4 +: MW]), 128'(111));
                        chk("t4_k0", 128'(gradient_magnitude[MW*0 +: MW]), 128'(100));
                    end
                end
            end
        end

        // Abort after six pixels, then resync with sof on a frame offset by 50
        for (int i = 0; i < 6; i++) pix(i / W, i % W, 0, (i == 0));
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pix(r, c, 50, (r == 0 && c == 0));
                if (r == 2 && c == 2) chk_first_window("t5_first", 50);
            end
        end

        // Asynchronous reset in the middle of row 3 while a window is showing
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (!(r == 3 && c == 3)) pix(r, c, 0, (r == 0 && c == 0));
            end
        end
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_valid", 128'(gradient_data_valid), 128'(0));
        chk("arst_eof", 128'(window_eof), 128'(0));
        chk("arst_mag", 128'(gradient_magnitude), 128'(0));
        chk("arst_dir", 128'(gradient_direction), 128'(0));
        mr = 0;
        mc = 0;
        known = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rstN = 1'b1;
        strobes = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pix(r, c, 0, 1'b0);
                if (r == 2 && c == 2) chk_first_window("t6_first", 0);
            end
        end
        cycle(1'b0, 1'b0, '0, '0);
        chk("t6_strobes", 128'(strobes), 128'((W - 2) * (H - 2)));

        // Random pixel data, random gaps, occasional resync
        for (int i = 0; i < 3 * W * H; i++) begin
            cycle(1'b1, (i == 0) || ($urandom_range(0, 40) == 0), MW'($urandom), DW'($urandom));
            if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'($urandom), MW'($urandom), DW'($urandom));
        end
        cycle(1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
